// File: rtl/dut_cmd_issuer.sv
// dut_cmd_issuer
//   Queues ALU commands in a small FIFO and issues them one at a time to an
//   external device. Each issued command waits for dev_done, or is abandoned
//   after TIMEOUT wait cycles. The result is then held on the response port
//   until it is accepted.
//
// Ports
//   clk, reset_n          clock; synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; payload cmd_a, cmd_b, cmd_op,
//                         cmd_op_pf, cmd_sv
//   dev_A/B/op/op_pf/sv   operands of the command in flight
//   dev_start             one-cycle issue pulse
//   dev_done, dev_result, dev_err   device completion and result
//   rsp_valid/rsp_ready   response handshake; payload rsp_result, rsp_err,
//                         rsp_timeout, rsp_seq (issue number of the command)
//   busy                  FSM not idle, or commands still queued
module dut_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [7:0]  cmd_op,
  input  logic        cmd_op_pf,
  input  logic        cmd_sv,
  output logic [31:0] dev_A,
  output logic [31:0] dev_B,
  output logic [7:0]  dev_op,
  output logic        dev_op_pf,
  output logic        dev_sv,
  output logic        dev_start,
  input  logic        dev_done,
  input  logic [63:0] dev_result,
  input  logic [5:0]  dev_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [5:0]  rsp_err,
  output logic        rsp_timeout,
  output logic [7:0]  rsp_seq,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 74;  // {a, b, op, op_pf, sv}

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [EW-1:0] r_dev;
  logic [7:0]    r_wait_cnt;
  logic [7:0]    r_issue_cnt;
  logic [7:0]    r_cur_seq;
  logic [63:0]   r_rsp_result;
  logic [5:0]    r_rsp_err;
  logic          r_rsp_timeout;
  logic [7:0]    r_rsp_seq;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_wait_expired;

  assign w_full         = (r_count == (AW + 1)'(DEPTH));
  assign w_empty        = (r_count == '0);
  assign w_wait_expired = (r_wait_cnt == 8'(TIMEOUT - 1));

  // Combinational outputs are gated by reset_n so that they read 0 for the
  // whole reset period, not only after the first reset edge.
  assign cmd_ready = reset_n & ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign busy      = reset_n & ((r_state != S_IDLE) | ~w_empty);

  assign {dev_A, dev_B, dev_op, dev_op_pf, dev_sv} = r_dev;
  assign rsp_result  = r_rsp_result;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_seq     = r_rsp_seq;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    dev_start   = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dev_start   = reset_n;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dev_done || w_wait_expired) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = reset_n;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage array carries no reset; emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op, cmd_op_pf, cmd_sv};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_dev         <= '0;
      r_wait_cnt    <= '0;
      r_issue_cnt   <= '0;
      r_cur_seq     <= '0;
      r_rsp_result  <= '0;
      r_rsp_err     <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_seq     <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // The issue counter only advances in ISSUE, which always follows the
      // pop, so its value at pop time is this command's sequence number.
      if (w_pop) begin
        r_dev     <= r_mem[r_rd_ptr];
        r_cur_seq <= r_issue_cnt;
      end

      if (r_state == S_ISSUE) begin
        r_issue_cnt <= r_issue_cnt + 1'b1;
        r_wait_cnt  <= '0;
      end

      if (r_state == S_WAIT) begin
        if (dev_done) begin
          r_rsp_result  <= dev_result;
          r_rsp_err     <= dev_err;
          r_rsp_timeout <= 1'b0;
          r_rsp_seq     <= r_cur_seq;
        end else if (w_wait_expired) begin
          r_rsp_result  <= '0;
          r_rsp_err     <= '0;
          r_rsp_timeout <= 1'b1;
          r_rsp_seq     <= r_cur_seq;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_cmd_issuer.sv
// tb_dut_cmd_issuer
//   Randomised bench for dut_cmd_issuer with a transaction-level reference:
//   a queue of accepted commands, a queue of expected responses, and a
//   device model that answers each start after a chosen delay (or never).
`timescale 1ns/1ps
module tb_dut_cmd_issuer;

  localparam int unsigned DEP = 4;
  localparam int unsigned TO  = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    logic        pf;
    logic        sv;
  } cmd_t;

  typedef struct packed {
    logic [63:0] res;
    logic [5:0]  err;
    logic        to;
    logic [7:0]  seq;
  } rsp_t;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [7:0]  cmd_op;
  logic        cmd_op_pf;
  logic        cmd_sv;
  logic [31:0] dev_A;
  logic [31:0] dev_B;
  logic [7:0]  dev_op;
  logic        dev_op_pf;
  logic        dev_sv;
  logic        dev_start;
  logic        dev_done;
  logic [63:0] dev_result;
  logic [5:0]  dev_err;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [5:0]  rsp_err;
  logic        rsp_timeout;
  logic [7:0]  rsp_seq;
  logic        busy;

  dut_cmd_issuer #(.DEPTH(DEP), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cmd_op_pf(cmd_op_pf), .cmd_sv(cmd_sv),
    .dev_A(dev_A), .dev_B(dev_B), .dev_op(dev_op),
    .dev_op_pf(dev_op_pf), .dev_sv(dev_sv), .dev_start(dev_start),
    .dev_done(dev_done), .dev_result(dev_result), .dev_err(dev_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_seq(rsp_seq), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  cmd_t        fifo_q[$];
  rsp_t        exp_q[$];
  cmd_t        cur_cmd;
  cmd_t        fc;
  bit          inflight, rsp_seen, lat_arm, use_fc;
  int unsigned issued, n_push, n_rsp, t_start, exp_lat, t_push;
  int          done_rem;
  int unsigned p_push, p_rdy, dmode, dfix;
  logic [5:0]  ferr;
  logic [63:0] pend_res;
  logic [5:0]  pend_err;
  int unsigned n_cmp, n_bad;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of stimulus + checking, performed at the falling edge.
  // Outputs seen here reflect the state after the previous rising edge;
  // inputs driven here are sampled at the next rising edge.
  task automatic step();
    cmd_t        c;
    rsp_t        r;
    int unsigned j;
    int unsigned k;
    bit          rdy;
    @(negedge clk);

    // device model
    dev_done   = 1'b0;
    dev_result = {$urandom, $urandom};
    dev_err    = 6'($urandom);
    if (done_rem > 0) begin
      done_rem--;
      if (done_rem == 0) begin
        dev_done   = 1'b1;
        dev_result = pend_res;
        dev_err    = pend_err;
      end
    end else if ((!inflight || rsp_valid) && $urandom_range(0, 7) == 0) begin
      dev_done = 1'b1;  // stray completion outside WAIT must be ignored
    end

    if (!inflight) chk("rsp_valid_idle", rsp_valid, 1'b0);
    if (inflight && !dev_start && !rsp_valid)
      chk("dev_hold", {dev_A, dev_B, dev_op, dev_op_pf, dev_sv}, cur_cmd);

    if (dev_start) begin
      chk("one_outstanding", inflight, 1'b0);
      if (lat_arm) begin
        chk("issue_latency", cyc + 1, t_push + 2);
        lat_arm = 1'b0;
      end
      if (fifo_q.size() == 0) begin
        chk("pop_from_empty", dev_start, 1'b0);
      end else begin
        cur_cmd = fifo_q.pop_front();
        chk("dev_ops", {dev_A, dev_B, dev_op, dev_op_pf, dev_sv}, cur_cmd);
        inflight = 1'b1;
        rsp_seen = 1'b0;
        t_start  = cyc + 1;  // edge at which WAIT is entered
        case (dmode)
          1: j = dfix;
          2: j = 0;
          3: j = TO + 2;
          default: begin
            k = $urandom_range(0, 9);
            if (k == 0)      j = 0;
            else if (k == 1) j = TO;
            else if (k == 2) j = $urandom_range(TO + 1, TO + 3);
            else             j = $urandom_range(1, TO - 1);
          end
        endcase
        if (dmode == 1) begin
          pend_res = 64'(cur_cmd.a) + 64'(cur_cmd.b);
          pend_err = ferr;
        end else begin
          pend_res = {$urandom, $urandom};
          pend_err = 6'($urandom);
        end
        done_rem = int'(j);
        // done sampled j edges into WAIT wins up to and including TO
        if (j != 0 && j <= TO) begin
          r.res = pend_res; r.err = pend_err; r.to = 1'b0; exp_lat = j;
        end else begin
          r.res = '0; r.err = '0; r.to = 1'b1; exp_lat = TO;
        end
        r.seq = 8'(issued);
        issued++;
        exp_q.push_back(r);
      end
    end

    chk("busy", busy, (fifo_q.size() != 0) || inflight);
    chk("cmd_ready", cmd_ready, fifo_q.size() < DEP);

    rdy = ($urandom_range(0, 99) < p_rdy);
    rsp_ready = rdy;
    if (rsp_valid) begin
      if (!rsp_seen && inflight) begin
        chk("resp_latency", cyc - t_start, exp_lat);
        rsp_seen = 1'b1;
      end
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        chk("rsp_payload", {rsp_result, rsp_err, rsp_timeout, rsp_seq}, exp_q[0]);
        if (rdy) begin
          void'(exp_q.pop_front());
          inflight = 1'b0;
          n_rsp++;
        end
      end
    end

    c = {$urandom, $urandom, 8'($urandom), 1'($urandom), 1'($urandom)};
    cmd_valid = ($urandom_range(0, 99) < p_push);
    if (use_fc) begin
      c         = fc;
      cmd_valid = 1'b1;
      use_fc    = 1'b0;
      if (fifo_q.size() == 0 && !inflight) begin
        lat_arm = 1'b1;
        t_push  = cyc + 1;
      end
    end
    {cmd_a, cmd_b, cmd_op, cmd_op_pf, cmd_sv} = c;
    if (cmd_valid && fifo_q.size() < DEP) begin
      fifo_q.push_back(c);
      n_push++;
    end
  endtask

  task automatic run_until_idle(input int unsigned budget);
    int unsigned k = 0;
    while ((fifo_q.size() != 0 || inflight) && k < budget) begin
      step();
      k++;
    end
    if (k == budget) chk("drain_timeout", {fifo_q.size(), inflight}, '0);
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      dev_done = 1'($urandom);
      chk("rst_ctrl", {cmd_ready, dev_start, rsp_valid, busy}, 4'b0);
      chk("rst_dev", {dev_A, dev_B, dev_op, dev_op_pf, dev_sv}, '0);
      chk("rst_rsp", {rsp_result, rsp_err, rsp_timeout, rsp_seq}, '0);
    end
    dev_done = 1'b0;
    reset_n  = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    inflight = 1'b0;
    done_rem = 0;
    issued   = 0;
    lat_arm  = 1'b0;
    use_fc   = 1'b0;
    #1 chk("ready_after_reset", cmd_ready, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; dev_done = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_op_pf = 1'b0; cmd_sv = 1'b0;
    dev_result = '0; dev_err = '0;
    inflight = 0; rsp_seen = 0; lat_arm = 0; use_fc = 0;
    issued = 0; n_push = 0; n_rsp = 0; t_start = 0; exp_lat = 0; t_push = 0;
    done_rem = 0; n_cmp = 0; n_bad = 0;
    p_push = 0; p_rdy = 100; dmode = 0; dfix = 1; ferr = '0;
    cur_cmd = '0; fc = '0; pend_res = '0; pend_err = '0;

    do_reset(3);

    // 5 + 7, device done 4 cycles after start
    fc = {32'd5, 32'd7, 8'h00, 1'b0, 1'b0};
    use_fc = 1'b1; dmode = 1; dfix = 4; ferr = '0; p_push = 0; p_rdy = 100;
    step();
    run_until_idle(60);

    // stalled device and response port: FIFO fills, 6th command refused
    dmode = 2; p_rdy = 0; p_push = 100;
    repeat (30) step();
    chk("stall_ready", cmd_ready, 1'b0);
    p_push = 0; p_rdy = 100; dmode = 0;
    run_until_idle(800);

    // timeout with a late done, then a normal command
    dmode = 3; fc = {$urandom, $urandom, 8'h3c, 1'b1, 1'b0}; use_fc = 1'b1;
    step();
    run_until_idle(100);
    dmode = 1; dfix = 2; fc = {32'd100, 32'd23, 8'h11, 1'b0, 1'b1}; use_fc = 1'b1;
    step();
    run_until_idle(60);

    // error response held for 10 cycles before acceptance
    begin
      int unsigned k = 0;
      dmode = 1; dfix = 3; ferr = 6'b000001; p_rdy = 0;
      fc = {32'd0, 32'd0, 8'h22, 1'b0, 1'b0}; use_fc = 1'b1;
      step();
      while (!rsp_valid && k < 40) begin
        step();
        k++;
      end
      if (k == 40) chk("resp_wait_timeout", rsp_valid, 1'b1);
      repeat (10) step();
      p_rdy = 100;
      step();
      step();
      chk("idle_after_accept", busy, 1'b0);
      ferr = '0;
    end

    // reset while one command waits and three are queued
    dmode = 2; p_rdy = 0; p_push = 100;
    repeat (4) step();
    p_push = 0;
    repeat (3) step();
    do_reset(2);
    dmode = 1; dfix = 2; p_rdy = 100;
    fc = {$urandom, $urandom, 8'h7f, 1'b1, 1'b1}; use_fc = 1'b1;
    step();
    run_until_idle(60);

    // random traffic
    dmode = 0; p_push = 35; p_rdy = 60;
    repeat (1500) step();
    p_push = 0; p_rdy = 100;
    run_until_idle(2000);

    // 257 back-to-back commands: sequence numbers wrap 255 -> 0
    do_reset(2);
    begin
      int unsigned n0 = n_push;
      int unsigned k  = 0;
      dmode = 1; dfix = 1; p_rdy = 100; p_push = 100;
      while ((n_push - n0) < 257 && k < 3000) begin
        step();
        k++;
      end
      p_push = 0;
      if (k == 3000) chk("push_budget", n_push - n0, 257);
      run_until_idle(1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dut_cmd_issuer.md
DUT_CMD_ISSUER -- requirements
Module: dut_cmd_issuer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the command FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles before a command is abandoned (2..255).
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  SHALL be a synchronous, active-low reset.
REQ-005 cmd_valid  in  1  upstream command valid.
REQ-006 cmd_ready  out  1  FIFO can accept a command.
REQ-007 cmd_a, cmd_b  in  32 each  operands.
REQ-008 cmd_op  in  8  opcode; cmd_op_pf  in  1  opcode prefix; cmd_sv  in  1  supervisor flag.
REQ-009 dev_A, dev_B  out  32 each; dev_op  out  8; dev_op_pf, dev_sv  out  1 each: operands to the ALU device.
REQ-010 dev_start  out  1  one-cycle start pulse to the device.
REQ-011 dev_done  in  1  device completion pulse.
REQ-012 dev_result  in  64; dev_err  in  6: device result and error vector.
REQ-013 rsp_valid  out  1; rsp_ready  in  1: response handshake.
REQ-014 rsp_result  out  64; rsp_err  out  6; rsp_timeout  out  1; rsp_seq  out  8: response payload.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-016 The FIFO SHALL push {a,b,op,op_pf,sv} on a cycle with cmd_valid=1 and cmd_ready=1.
REQ-017 cmd_ready SHALL equal !full with no look-ahead: a full FIFO SHALL refuse a push even when a pop occurs in the same cycle.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; a push and a pop in the same cycle on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry, register it onto the dev_* operand outputs, and go to ISSUE.
REQ-021 In IDLE with the FIFO empty, the FSM SHALL stay in IDLE.
REQ-022 dev_start SHALL be high for exactly the single ISSUE cycle; the FSM SHALL then go to WAIT and clear the wait counter.
REQ-023 The dev_* operand outputs SHALL hold stable from ISSUE until the FSM leaves WAIT.
REQ-024 In WAIT, dev_done=1 SHALL capture dev_result into rsp_result and dev_err into rsp_err, clear rsp_timeout, and move the FSM to RESP.
REQ-025 In WAIT, the counter SHALL increment each cycle without dev_done.
REQ-026 If the counter reaches TIMEOUT-1 with dev_done=0, the FSM SHALL go to RESP with rsp_result=0, rsp_err=0 and rsp_timeout=1.
REQ-027 If dev_done arrives on the same cycle the counter reaches TIMEOUT-1, dev_done SHALL take priority and no timeout SHALL be reported.
REQ-028 dev_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-029 In RESP, rsp_valid SHALL be 1 and the payload SHALL be stable until rsp_ready=1; the FSM SHALL then return to IDLE on the next edge.
REQ-030 rsp_seq SHALL be the issue count of the command, starting at 0 after reset and incrementing by 1 per ISSUE, wrapping 255->0.
REQ-031 Latency: a command pushed at edge t into an empty FIFO with the FSM in IDLE SHALL be popped at t+1 and produce dev_start at t+2.
REQ-032 Only one command SHALL be outstanding at the device at a time.
REQ-033 The FIFO SHALL continue accepting commands while the FSM is in ISSUE, WAIT or RESP.

Reset
REQ-034 While reset_n=0, the FSM SHALL go to IDLE, the FIFO SHALL empty, and the wait counter and the rsp_seq counter SHALL clear to 0.
REQ-035 While reset_n=0, every output SHALL be 0, including cmd_ready, dev_start, rsp_valid, busy, all dev_* outputs and all rsp_* outputs.
REQ-036 A reset in any state, including mid-WAIT or mid-RESP, SHALL discard the in-flight command and all queued commands.
REQ-037 A dev_done arriving after reset is released SHALL be ignored per REQ-028.
REQ-038 cmd_ready SHALL be 1 on the first cycle after reset_n returns high.

Verification
REQ-039 Push a=5, b=7, op=00 (pf=0, sv=0); device model asserts done 4 cycles after start with result 12 -> dev_start at t+2, rsp_result=64'd12, rsp_err=0, rsp_timeout=0, rsp_seq=0.
REQ-040 Hold rsp_ready=0, device stalled, push 6 commands (DEPTH=4) -> 1 command in flight, 4 queued, cmd_ready=0 on the 6th, which is not accepted until a pop occurs.
REQ-041 Device never asserts done -> RESP entered exactly TIMEOUT cycles after WAIT entry with rsp_timeout=1 and rsp_result=0; a late done is ignored; the next command proceeds normally.
REQ-042 Device returns dev_err=6'b000001 with result 0 and rsp_ready held low 10 cycles -> payload stable for all 10 cycles, accepted on the cycle rsp_ready rises, FSM back in IDLE on the next edge.
REQ-043 Reset asserted mid-WAIT with 3 commands queued -> all outputs 0, FIFO empty, rsp_seq=0 on the next response, no stale response emitted.
REQ-044 Issue 257 back-to-back commands -> rsp_seq runs 0..255 then 0, and the responses arrive in push order.
